fuzz_stim_sequencer: RTL and testbench

Controller that sequences a synthesised fuzz `top` netlist during identity/equivalence runs. It replaces free-running testbench stimulus with a clocked engine that:
- stores a vector table,
- applies one vector at a time to the DUT input bus,
- waits a programmable settle latency, then folds the DUT output `y` into a running signature,
- compares the final signature against an expected value.

It sits between the bench/loader and the `top` instance, so RTL and synthesised netlists are checked by one 32-bit compare.

---
 rtl/fuzz_seq_pkg.sv | 28 ++
 rtl/fuzz_vec_ram.sv | 21 ++
 rtl/fuzz_stim_sequencer.sv | 132 +++++++++++++
 tb/tb_fuzz_stim_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_seq_pkg.sv
// Shared types and constants for the fuzz stimulus sequencer.
// Widths match the synthesised fuzz `top` netlist.
package fuzz_seq_pkg;
  localparam int          TOP_VEC_W   = 63;
  localparam int          TOP_Y_W     = 550;
  localparam int          TOP_SIG_W   = 32;
  localparam int          FOLD_CHUNKS = 18;
  localparam logic [31:0] POLY_DEF    = 32'h04C11DB7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPLY    = 3'd1,
    S_SETTLE_W = 3'd2,
    S_CAPTURE  = 3'd3,
    S_FINISH   = 3'd4
  } state_e;

  // Zero-extend y to a whole number of signature words, then XOR them together.
  function automatic logic [TOP_SIG_W-1:0] fold(input logic [TOP_Y_W-1:0] y);
    logic [FOLD_CHUNKS*TOP_SIG_W-1:0] ext;
    logic [TOP_SIG_W-1:0]             acc;
    ext = '0;
    ext[TOP_Y_W-1:0] = y;
    acc = '0;
    for (int k = 0; k < FOLD_CHUNKS; k++) acc ^= ext[k*TOP_SIG_W +: TOP_SIG_W];
    return acc;
  endfunction
endpackage

// File: rtl/fuzz_vec_ram.sv
// Vector table: one synchronous write port, asynchronous read, no reset.
module fuzz_vec_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int VEC_W = 63
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [VEC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Clocked stimulus engine: applies table vectors to the DUT, waits SETTLE cycles,
// folds y into a CRC-style signature and compares against an expected value.
module fuzz_stim_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int               VEC_W  = TOP_VEC_W,
  parameter int               Y_W    = TOP_Y_W,
  parameter int               DEPTH  = 32,
  parameter int               AW     = 5,
  parameter int               SIG_W  = TOP_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = POLY_DEF,
  parameter int               SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  input  logic [VEC_W-1:0] ld_data,
  input  logic [AW:0]      num_vec,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             start,
  output logic [VEC_W-1:0] dut_in,
  input  logic [Y_W-1:0]   dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [AW:0]      vec_idx
);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] dut_in_q, dut_in_d;
  logic [SIG_W-1:0] sig_q, sig_d, exp_q, exp_d;
  logic [AW:0]      vec_idx_q, vec_idx_d, num_q, num_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pass_q, pass_d, done_q, done_d;
  logic [VEC_W-1:0] rd_data;
  logic             last_vec;

  fuzz_vec_ram #(.DEPTH(DEPTH), .AW(AW), .VEC_W(VEC_W)) u_ram (
    .clk   (clk),
    .we    (ld_valid),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (vec_idx_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign last_vec = ((vec_idx_q + 1'b1) == num_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // start outside IDLE is deliberately not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = (num_vec == '0) ? S_FINISH : S_APPLY;
      S_APPLY:    state_d = S_SETTLE_W;
      S_SETTLE_W: if (cnt_q == '0) state_d = S_CAPTURE;
      S_CAPTURE:  state_d = last_vec ? S_FINISH : S_APPLY;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dut_in_d  = dut_in_q;
    sig_d     = sig_q;
    exp_d     = exp_q;
    vec_idx_d = vec_idx_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        num_d     = num_vec;
        exp_d     = exp_sig;
        sig_d     = '0;
        vec_idx_d = '0;
        pass_d    = 1'b0;
      end
      S_APPLY: begin
        dut_in_d = rd_data;
        cnt_d    = SETTLE_LD;
      end
      S_SETTLE_W: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      S_CAPTURE: begin
        sig_d     = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold(dut_y);
        vec_idx_d = vec_idx_q + 1'b1;
      end
      S_FINISH: begin
        pass_d = (sig_q == exp_q);
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in_q  <= '0;
      sig_q     <= '0;
      exp_q     <= '0;
      vec_idx_q <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dut_in_q  <= dut_in_d;
      sig_q     <= sig_d;
      exp_q     <= exp_d;
      vec_idx_q <= vec_idx_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
    end
  end

  // done and pass leave FINISH registered, so they land in the first IDLE cycle with busy low.
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign pass    = pass_q;
  assign sig     = sig_q;
  assign vec_idx = vec_idx_q;
  assign dut_in  = dut_in_q;
endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Scoreboard bench for fuzz_stim_sequencer: runs queue expected results, a monitor checks them on done.
module tb_fuzz_stim_sequencer;
  localparam int          VW   = 63;
  localparam int          YW   = 550;
  localparam int          AW   = 5;
  localparam int          SW   = 32;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [VW-1:0] ld_data;
  logic [AW:0]   num_vec;
  logic [SW-1:0] exp_sig;
  logic          start;
  logic [VW-1:0] dut_in;
  logic [YW-1:0] dut_y;
  logic          busy, done, pass;
  logic [SW-1:0] sig;
  logic [AW:0]   vec_idx;

  typedef struct {
    logic [SW-1:0] sig;
    logic          pass;
    logic [AW:0]   idx;
    logic [VW-1:0] din;
    int            lat;
    int            start_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [VW-1:0] T0   = 63'h0A84B4F6DF72F591;
  localparam logic [VW-1:0] T1   = 63'h123456789ABCDEF0;
  localparam logic [VW-1:0] T2   = 63'h5555AAAA0F0FF0F0;
  localparam logic [VW-1:0] ONES = {VW{1'b1}};

  logic [YW-1:0] yv;
  logic [SW-1:0] s;

  fuzz_stim_sequencer dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .exp_sig(exp_sig), .start(start), .dut_in(dut_in), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .sig(sig), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [SW-1:0] sg, input logic ps, input logic [AW:0] ix,
                              input logic [VW-1:0] dn, input int lt);
    exp_t e;
    e.sig = sg; e.pass = ps; e.idx = ix; e.din = dn; e.lat = lt; e.start_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = q.pop_front();
        chk("done_sig", sig, e.sig);
        chk("done_pass", pass, e.pass);
        chk("done_vec_idx", vec_idx, e.idx);
        chk("done_dut_in", dut_in, e.din);
        chk("done_latency", cyc - e.start_cyc, e.lat);
        chk("done_busy_low", busy, 0);
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [VW-1:0] d);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // Returns #1 after the edge that samples start.
  task automatic run(input logic [AW:0] n, input logic [SW-1:0] es, input exp_t e, input bit expect_done);
    exp_t r;
    r = e;
    @(posedge clk); #1;
    start = 1'b1; num_vec = n; exp_sig = es;
    r.start_cyc = cyc;
    if (expect_done) q.push_back(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    num_vec = '0; exp_sig = '0; start = 1'b0; dut_y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", sig, 0);
    chk("rst_vec_idx", vec_idx, 0);

    // Empty run: straight to FINISH, signature equals 0.
    run(0, 32'h0, mk(32'h0, 1'b1, 0, '0, 2), 1'b1);
    drain(50);

    // Single vector, y=1.
    load(0, T0);
    dut_y = 550'h1;
    run(1, 32'h1, mk(32'h1, 1'b1, 1, T0, 6), 1'b1);
    drain(50);
    run(1, 32'h2, mk(32'h1, 1'b0, 1, T0, 6), 1'b1);
    drain(50);

    // Fold: bit 549 lands in bit 5 of the last chunk, bits 160/162 in chunk 5 -> 0x25.
    yv = '0; yv[549] = 1'b1; yv[160] = 1'b1; yv[162] = 1'b1;
    dut_y = yv;
    run(1, 32'h25, mk(32'h25, 1'b1, 1, T0, 6), 1'b1);
    drain(50);

    // Two vectors, y=1: sig 1 then 3.
    load(1, T1);
    dut_y = 550'h1;
    run(2, 32'h3, mk(32'h3, 1'b1, 2, T1, 10), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_sig", sig, 32'h1);
    chk("mid_vec_idx", vec_idx, 1);
    chk("mid_dut_in", dut_in, T0);
    chk("mid_busy", busy, 1);
    drain(100);

    // start while busy plus a write to the entry being applied.
    run(2, 32'h3, mk(32'h3, 1'b1, 2, T1, 10), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; num_vec = 0; ld_valid = 1'b1; ld_addr = 1; ld_data = T2;
    @(posedge clk); #1;
    start = 1'b0; ld_valid = 1'b0;
    chk("collide_old_data", dut_in, T1);
    drain(100);
    run(2, 32'h3, mk(32'h3, 1'b1, 2, T2, 10), 1'b1);
    drain(100);

    // Full table of all-ones; fold of all-ones y is 0xFFFFFFC0 (17 full chunks + 6 low ones).
    for (int i = 0; i < 32; i++) load(5'(i), ONES);
    dut_y = '1;
    s = '0;
    for (int i = 0; i < 32; i++) s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ 32'hFFFFFFC0;
    run(32, s, mk(s, 1'b1, 32, ONES, 130), 1'b1);
    drain(400);

    // Reset during the second vector's settle: no done, outputs cleared.
    run(4, 32'h0, mk(32'h0, 1'b0, 0, '0, 0), 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_dut_in", dut_in, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sig", sig, 0);
    chk("abort_vec_idx", vec_idx, 0);
    chk("abort_pass", pass, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    dut_y = 550'h1;
    run(1, 32'h1, mk(32'h1, 1'b1, 1, ONES, 6), 1'b1);
    drain(50);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
